// File: rtl/vga_fb_pkg.sv
// Shared VGA timing constants, frame-buffer FSM states and the scaled
// cell-address helper used by the frame buffer and its bench.
package vga_fb_pkg;

    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int H_OFFSET_DEF = 160;
    localparam int V_OFFSET_DEF = 45;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fb_state_t;

    // Linear cell index of visible-area pixel (x, y) in a grid mem_w cells wide.
    function automatic logic [31:0] scaled_addr(
        input logic [9:0] x,
        input logic [9:0] y,
        input int         mem_w,
        input int         scale_log2
    );
        logic [31:0] row;
        logic [31:0] col;
        row = 32'(y >> scale_log2);
        col = 32'(x >> scale_log2);
        return row * unsigned'(mem_w) + col;
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// read-first on a same-address collision.
module vga_fb_ram #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 19200,
    parameter int AW    = 15
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both accesses share one edge, so a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vga_frame_buffer.sv
// Down-scaled pixel frame buffer with valid/ready writes, a clear engine and
// blanking-aware readout. Define VGA_FRAME_BUFFER_DOUBLE_BUFFER_EN for two pages.
module vga_frame_buffer
    import vga_fb_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int H_OFFSET   = H_OFFSET_DEF,
    parameter int V_OFFSET   = V_OFFSET_DEF,
    parameter int SCALE_LOG2 = 2,
    parameter int COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_en,
    input  logic [9:0]           hcount,
    input  logic [9:0]           vcount,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [9:0]           wr_x,
    input  logic [9:0]           wr_y,
    input  logic [COLOR_W-1:0]   wr_color,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 wr_oob,
    output logic [COLOR_W/3-1:0] vr,
    output logic [COLOR_W/3-1:0] vg,
    output logic [COLOR_W/3-1:0] vb,
    input  logic                 swap_req
);

    localparam int CW     = COLOR_W / 3;
    localparam int MEM_W  = H_RES >> SCALE_LOG2;
    localparam int MEM_H  = V_RES >> SCALE_LOG2;
    localparam int DEPTH  = MEM_W * MEM_H;
    localparam int ADDR_W = $clog2(DEPTH);
`ifdef VGA_FRAME_BUFFER_DOUBLE_BUFFER_EN
    localparam int RAM_DEPTH = 2 * DEPTH;
`else
    localparam int RAM_DEPTH = DEPTH;
`endif
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DEPTH - 1);
    localparam logic [9:0] X_LIM   = 10'(H_RES);
    localparam logic [9:0] Y_LIM   = 10'(V_RES);
    localparam logic [9:0] H_START = 10'(H_OFFSET);
    localparam logic [9:0] H_END   = 10'(H_OFFSET + H_RES);
    localparam logic [9:0] V_START = 10'(V_OFFSET);
    localparam logic [9:0] V_END   = 10'(V_OFFSET + V_RES);

    fb_state_t           state_reg, state_next;
    logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;
    logic                wr_oob_reg;
    logic                active_reg;

    logic                wr_in_range;
    logic                wr_fire;
    logic [ADDR_W-1:0]   wr_cell;
    logic                rd_active;
    logic [9:0]          rd_x, rd_y;
    logic [ADDR_W-1:0]   rd_cell;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_wcell;
    logic [COLOR_W-1:0]  ram_wdata;
    logic [COLOR_W-1:0]  ram_rdata;
    logic [RAM_AW-1:0]   ram_waddr, ram_raddr;

    assign wr_in_range = (wr_x < X_LIM) && (wr_y < Y_LIM);
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_cell     = ADDR_W'(scaled_addr(wr_x, wr_y, MEM_W, SCALE_LOG2));

    assign rd_active = (hcount >= H_START) && (hcount < H_END) &&
                       (vcount >= V_START) && (vcount < V_END);
    assign rd_x      = hcount - H_START;
    assign rd_y      = vcount - V_START;
    assign rd_cell   = rd_active ? ADDR_W'(scaled_addr(rd_x, rd_y, MEM_W, SCALE_LOG2))
                                 : '0;

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        busy          = 1'b0;
        wr_ready      = 1'b0;
        ram_we        = 1'b0;
        ram_wcell     = wr_cell;
        ram_wdata     = wr_color;
        case (state_reg)
            CLEAR: begin
                busy          = 1'b1;
                ram_we        = 1'b1;
                ram_wcell     = clr_addr_reg;
                ram_wdata     = BG_COLOR;
                clr_addr_next = clr_addr_reg + ADDR_W'(1);
                if (clr_addr_reg == LAST_CELL) begin
                    state_next    = RUN;
                    clr_addr_next = '0;
                end
            end
            RUN: begin
                wr_ready = 1'b1;
                // Out-of-range handshakes complete but never reach the RAM.
                ram_we   = wr_valid && wr_in_range;
                if (clear_req) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            default: begin
                state_next    = CLEAR;
                clr_addr_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
            wr_oob_reg   <= 1'b0;
            active_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            if (wr_fire && !wr_in_range) begin
                wr_oob_reg <= 1'b1;
            end
            if (pix_en) begin
                active_reg <= rd_active && !busy;
            end
        end
    end

    assign wr_oob = wr_oob_reg;

`ifdef VGA_FRAME_BUFFER_DOUBLE_BUFFER_EN
    logic front_reg;
    logic swap_pend_reg;
    logic swap_now;

    function automatic logic [RAM_AW-1:0] page_addr(input logic page,
                                                    input logic [ADDR_W-1:0] cell);
        return RAM_AW'(cell) + (page ? RAM_AW'(DEPTH) : RAM_AW'(0));
    endfunction

    assign swap_now = swap_pend_reg && pix_en && !busy &&
                      (hcount == 10'd0) && (vcount == 10'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_reg     <= 1'b0;
            swap_pend_reg <= 1'b0;
        end else if (swap_now) begin
            front_reg     <= ~front_reg;
            // A request landing on the swap cycle itself waits for the next frame.
            swap_pend_reg <= swap_req;
        end else if (swap_req) begin
            swap_pend_reg <= 1'b1;
        end
    end

    assign ram_waddr = page_addr(~front_reg, ram_wcell);
    assign ram_raddr = page_addr(front_reg, rd_cell);
`else
    logic unused_swap;
    assign unused_swap = swap_req;
    assign ram_waddr   = ram_wcell;
    assign ram_raddr   = rd_cell;
`endif

    vga_fb_ram #(
        .WIDTH (COLOR_W),
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (pix_en),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // The RAM read register is the pixel register; blanking gates its output.
    logic [CW-1:0] chan [3];
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan[gi] = active_reg ? ram_rdata[gi*CW +: CW] : '0;
        end
    endgenerate

    assign vr = chan[0];
    assign vb = chan[1];
    assign vg = chan[2];

endmodule

// File: doc/vga_frame_buffer.md
Name: vga_frame_buffer

Overview:
- Parametrised pixel frame buffer between the host pixel writer and the VGA timing generator; successor to the single-pixel video memory.
- Synchronous single-clock design with a down-scaled storage grid, a valid/ready write port and a hardware clear engine.
- Blanking-aware readout with registered RGB outputs.
- Optional double buffering with tear-free page swap at frame start.

Parameters:
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- H_OFFSET, 160, hcount value of first visible pixel
- V_OFFSET, 45, vcount value of first visible line
- SCALE_LOG2, 2, each stored cell covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels
- COLOR_W, 12, stored colour width; must be a multiple of 3
- BG_COLOR, 12'h000, value written by the clear engine

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- pix_en  in  1  pixel-rate clock enable from timing generator
- hcount  in  10  raw horizontal counter, porches included
- vcount  in  10  raw vertical counter, porches included
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_x  in  10  visible-area x (0..H_RES-1)
- wr_y  in  10  visible-area y (0..V_RES-1)
- wr_color  in  COLOR_W  pixel colour {g,b,r}, 4 bits each at the default width
- clear_req  in  1  one-cycle pulse: fill buffer with BG_COLOR
- busy  out  1  clear in progress
- wr_oob  out  1  sticky flag: an out-of-range write was dropped
- vr, vg, vb  out  COLOR_W/3 each  colour outputs to DAC
- swap_req  in  1  page swap request (DOUBLE_BUFFER_EN only)

Interface rule: one clock (clk); reset is asynchronous and active-high.

Behaviour:
- Geometry: MEM_W = H_RES>>SCALE_LOG2, MEM_H = V_RES>>SCALE_LOG2, DEPTH = MEM_W*MEM_H (19200 at defaults). Address = (y>>SCALE_LOG2)*MEM_W + (x>>SCALE_LOG2), computed at the address width ceil(log2(DEPTH)).
- Reset values:
  - vr/vg/vb = 0, wr_oob = 0, busy = 1, wr_ready = 0.
  - The FSM enters CLEAR with the clear address at 0.
- FSM states:
  - CLEAR: writes BG_COLOR to one address per clk. After writing DEPTH-1 it goes to RUN on the next edge. Clearing takes exactly DEPTH cycles. busy=1, wr_ready=0.
  - RUN: busy=0, wr_ready=1. A clear_req pulse goes to CLEAR with the address reset to 0.
- clear_req while in CLEAR is ignored; the clear is not restarted.
- reset asserted mid-clear restarts the clear from address 0 after reset deassertion.
- Write port:
  - A handshake in RUN writes wr_color at the scaled address on that clk edge.
  - wr_x >= H_RES or wr_y >= V_RES: the handshake completes, nothing is written, and wr_oob is set. wr_oob clears only on reset.
- Readout:
  - Active when H_OFFSET <= hcount < H_OFFSET+H_RES and V_OFFSET <= vcount < V_OFFSET+V_RES.
  - On a clk with pix_en=1, the outputs register the stored colour for (hcount-H_OFFSET, vcount-V_OFFSET), split r=[COLOR_W/3-1:0], b=middle third, g=top third. Latency is 1 clk.
  - Outside the active area, or while busy, pix_en=1 loads 0.
  - pix_en=0: outputs hold.
- Read/write collision on the same address in the same cycle: read-first, so the output shows the old data and the new data is visible from the next access.
- Counters supplied outside 0..799 / 0..524 are simply non-active; no error is flagged.

Optional Feature:
- Macro: VGA_FRAME_BUFFER_DOUBLE_BUFFER_EN.
- Defined:
  - Two pages, each DEPTH deep. Writes and clears target the back page; readout uses the front page.
  - swap_req sets a pending flag. At the first pix_en cycle with hcount==0 and vcount==0, the page select toggles and the flag clears.
  - Multiple requests before frame start yield one swap.
  - The swap is deferred while busy.
- Undefined:
  - Single page; the swap_req port is present but ignored.

Decomposition:
- Package vga_fb_pkg holds:
  - the VGA timing constants (800x525 totals, default offsets)
  - the FSM state typedef {CLEAR, RUN}
  - a function for the scaled-address computation
- One sub-module, vga_fb_ram: simple dual-port synchronous RAM with one write port, one registered read port, read-first behaviour, and parametrised width and depth. It holds both pages in double-buffer mode.

Test Plan:
- Reset, then hold → busy=1 for exactly 19200 clks, then busy=0 and wr_ready=1. Every active pixel reads 12'h000.
- Write (x=4,y=8,color=12'hA5C), then scan hcount=164,vcount=53 with pix_en → next clk vr=4'hC, vb=4'h5, vg=4'hA. The same value appears at hcount=167, vcount=56 (same 4x4 cell).
- Scan hcount=100, vcount=200 (blanking) → outputs 0 regardless of memory contents.
- Write x=640,y=0 → handshake completes, wr_oob=1, and the cell (0,0) is unchanged.
- clear_req mid-frame after writes → busy for 19200 clks, outputs 0 during clear, all cells read BG_COLOR afterwards. A second clear_req during the clear does not extend busy.
- DOUBLE_BUFFER_EN: write 12'hFFF to the back page, pulse swap_req at vcount=300 → display unchanged until hcount=0,vcount=0. From the next frame, active pixels show vr=vg=vb=4'hF.
